synth6_protocol_sequencer: RTL

Cycle-accurate valve/actuator sequencer driving the Planar_Synthetic_6 chip. It is the control stage directly upstream of the flow network. After `start`, it admits the 12 sources one at a time and enables the mixing pumps. It then enables Heater1–3, routes flow_switch4_5 to Filter6 and then to Filter7, and finally dispenses to Out1. Each phase lasts a parameterised number of clock cycles.

---
 rtl/synth6_seq_pkg.sv | 73 +++++++
 rtl/seq_phase_timer.sv | 27 ++
 rtl/synth6_protocol_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/synth6_seq_pkg.sv
// Shared types, constants and output decode for the Planar_Synthetic_6 sequencer.
// The optional statistics counters are enabled with SYNTH6_SEQ_STATS_EN.
package synth6_seq_pkg;

   localparam int NUM_SRC = 12;
   localparam int IDX_W   = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_MIX    = 3'd2,
      S_HEAT   = 3'd3,
      S_FILT_A = 3'd4,
      S_FILT_B = 3'd5,
      S_DISP   = 3'd6,
      S_DONE   = 3'd7
   } seq_state_e;

   localparam logic [1:0] ROUTE_CLOSED = 2'd0;
   localparam logic [1:0] ROUTE_F6     = 2'd1;
   localparam logic [1:0] ROUTE_F7     = 2'd2;
   localparam logic [1:0] ROUTE_OUT    = 2'd3;

   typedef struct packed {
      logic               ready;
      logic               busy;
      logic               done;
      logic [NUM_SRC-1:0] src_en;
      logic               mix_en;
      logic [2:0]         heat_en;
      logic [1:0]         route;
   } act_s;

   // Everything not named for a state stays at zero.
   function automatic act_s decode_outputs(seq_state_e st, logic [IDX_W-1:0] idx);
      act_s a;
      logic [NUM_SRC-1:0] one_hot;
      a       = '0;
      one_hot = {{(NUM_SRC-1){1'b0}}, 1'b1};
      case (st)
         S_IDLE:   a.ready = 1'b1;
         S_LOAD: begin
            a.busy   = 1'b1;
            a.src_en = one_hot << idx;
         end
         S_MIX: begin
            a.busy   = 1'b1;
            a.mix_en = 1'b1;
         end
         S_HEAT: begin
            a.busy    = 1'b1;
            a.heat_en = 3'b111;
         end
         S_FILT_A: begin
            a.busy  = 1'b1;
            a.route = ROUTE_F6;
         end
         S_FILT_B: begin
            a.busy  = 1'b1;
            a.route = ROUTE_F7;
         end
         S_DISP: begin
            a.busy  = 1'b1;
            a.route = ROUTE_OUT;
         end
         S_DONE:   a.done = 1'b1;
         default:  a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Down-counting phase timer: load wins over hold, counting stops at zero.
module seq_phase_timer #(
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          hold,
   output logic          zero
);

   logic [TW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (!hold && (count_reg != '0)) begin
         count_reg <= count_reg - TW'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/synth6_protocol_sequencer.sv
// Valve/actuator sequencer: LOAD x12 -> MIX -> HEAT -> FILT_A -> FILT_B -> DISP -> DONE.
// Define SYNTH6_SEQ_STATS_EN to get saturating run/abort counters.
module synth6_protocol_sequencer
   import synth6_seq_pkg::*;
#(
   parameter int LOAD_CYCLES = 4,
   parameter int MIX_CYCLES  = 16,
   parameter int HEAT_CYCLES = 32,
   parameter int FILT_CYCLES = 8,
   parameter int DISP_CYCLES = 8,
   parameter int TW          = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         pause,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [2:0]   phase,
   output logic [11:0]  src_en,
   output logic         mix_en,
   output logic [2:0]   heat_en,
   output logic [1:0]   route,
   output logic [15:0]  run_count,
   output logic [15:0]  abort_count
);

   localparam logic [TW-1:0] LOAD_VAL = TW'(LOAD_CYCLES - 1);
   localparam logic [TW-1:0] MIX_VAL  = TW'(MIX_CYCLES - 1);
   localparam logic [TW-1:0] HEAT_VAL = TW'(HEAT_CYCLES - 1);
   localparam logic [TW-1:0] FILT_VAL = TW'(FILT_CYCLES - 1);
   localparam logic [TW-1:0] DISP_VAL = TW'(DISP_CYCLES - 1);

   seq_state_e       state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   act_s             act_reg;
   logic             aborted_reg, aborted_next;
   logic             tmr_load, tmr_hold, tmr_zero;
   logic [TW-1:0]    tmr_val;

   seq_phase_timer #(
      .TW (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .hold     (tmr_hold),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      tmr_hold     = 1'b0;
      aborted_next = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_LOAD;
               idx_next   = '0;
               tmr_load   = 1'b1;
               tmr_val    = LOAD_VAL;
            end
         end
         S_DONE: state_next = S_IDLE;
         default: begin
            if (abort) begin
               // Clear the timer too so a later run starts from a clean count.
               state_next   = S_IDLE;
               idx_next     = '0;
               tmr_load     = 1'b1;
               tmr_val      = '0;
               aborted_next = 1'b1;
            end else if (pause) begin
               tmr_hold = 1'b1;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               case (state_reg)
                  S_LOAD: begin
                     if (idx_reg != LAST_IDX) begin
                        idx_next = idx_reg + IDX_W'(1);
                        tmr_val  = LOAD_VAL;
                     end else begin
                        state_next = S_MIX;
                        tmr_val    = MIX_VAL;
                     end
                  end
                  S_MIX: begin
                     state_next = S_HEAT;
                     tmr_val    = HEAT_VAL;
                  end
                  S_HEAT: begin
                     state_next = S_FILT_A;
                     tmr_val    = FILT_VAL;
                  end
                  S_FILT_A: begin
                     state_next = S_FILT_B;
                     tmr_val    = FILT_VAL;
                  end
                  S_FILT_B: begin
                     state_next = S_DISP;
                     tmr_val    = DISP_VAL;
                  end
                  S_DISP: begin
                     state_next = S_DONE;
                     tmr_load   = 1'b0;
                  end
                  default: tmr_load = 1'b0;
               endcase
            end
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         idx_reg     <= '0;
         act_reg     <= decode_outputs(S_IDLE, '0);
         aborted_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         act_reg     <= decode_outputs(state_next, idx_next);
         aborted_reg <= aborted_next;
      end
   end

   assign phase   = state_reg;
   assign ready   = act_reg.ready;
   assign busy    = act_reg.busy;
   assign done    = act_reg.done;
   assign aborted = aborted_reg;
   assign src_en  = act_reg.src_en;
   assign mix_en  = act_reg.mix_en;
   assign heat_en = act_reg.heat_en;
   assign route   = act_reg.route;

`ifdef SYNTH6_SEQ_STATS_EN
   logic [15:0] run_count_reg, abort_count_reg;

   // Counters step together with the done/aborted pulse they count.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_count_reg   <= '0;
         abort_count_reg <= '0;
      end else begin
         if ((state_next == S_DONE) && (state_reg != S_DONE) && (run_count_reg != 16'hFFFF))
            run_count_reg <= run_count_reg + 16'd1;
         if (aborted_next && (abort_count_reg != 16'hFFFF))
            abort_count_reg <= abort_count_reg + 16'd1;
      end
   end

   assign run_count   = run_count_reg;
   assign abort_count = abort_count_reg;
`else
   assign run_count   = 16'd0;
   assign abort_count = 16'd0;
`endif

endmodule
